vga_pixel_render: RTL and testbench

Display-side consumer of the frame-buffer prefetch stage, running entirely in the VGA pixel clock domain. It takes the 16-bit prefetch-RAM word for the current column and turns it into one 8-bit palette index per pixel. In text mode it does the glyph lookup through an external font ROM, and it also handles cursor and blink. It sits between the prefetch RAM read port and the palette/DAC stage.

---
 rtl/vga_pixel_render.sv | 178 +++++++++++++++++
 tb/tb_vga_pixel_render.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_render.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : vga_pixel_render
// Purpose  : Converts prefetch-RAM words into 8-bit palette indices, one pixel
//            per vga_clk. Supports text mode (font ROM, cursor), 4-colour and
//            256-colour modes. Optional macro VGA_TEXT_BLINK_EN enables
//            character blink and a blinking cursor.
// Revision : 1.0 - initial release
//==============================================================================
module vga_pixel_render #(
  parameter logic [3:0] CURSOR_FIRST_LINE = 4'd14,
  parameter logic [3:0] CURSOR_LAST_LINE  = 4'd15
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic        de,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
  input  logic [15:0] q,
  output logic [11:0] font_address,
  input  logic [7:0]  font_data,
  input  logic        cursor_enable,
  input  logic [4:0]  cursor_row,
  input  logic [6:0]  cursor_col,
  output logic [7:0]  pixel,
  output logic        pixel_valid
);

  localparam logic [1:0] c_MODE_TEXT      = 2'd0;
  localparam logic [1:0] c_MODE_4_COLOR   = 2'd1;
  localparam logic [1:0] c_MODE_256_COLOR = 2'd2;
  localparam logic [3:0] c_CURSOR_SPAN    = CURSOR_LAST_LINE - CURSOR_FIRST_LINE;

  // S0: combinational decode of the raw row/col
  logic [3:0] w_line_ofs;
  logic       w_cursor_hit;
  logic       w_frame_start;

  // Offset compare keeps the line range check valid for any first/last pair.
  assign w_line_ofs    = row[3:0] - CURSOR_FIRST_LINE;
  assign w_cursor_hit  = cursor_enable && (row[8:4] == cursor_row) &&
                         (col[9:3] == cursor_col) && (w_line_ofs <= c_CURSOR_SPAN);
  assign w_frame_start = de && (row == 10'd0) && (col == 10'd0);

  logic [4:0] r_frame_count;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= 5'd0;
    end else if (w_frame_start) begin
      r_frame_count <= r_frame_count + 5'd1;
    end
  end

  // S1 registers
  logic       r_s1_de;
  logic [1:0] r_s1_mode;
  logic [3:0] r_s1_row;
  logic [3:0] r_s1_col;
  logic       r_s1_hit;

  // S2 registers
  logic        r_s2_de;
  logic [1:0]  r_s2_mode;
  logic [3:0]  r_s2_col;
  logic        r_s2_hit;
  logic [15:0] r_s2_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_de   <= 1'b0;
      r_s1_mode <= 2'd0;
      r_s1_row  <= 4'd0;
      r_s1_col  <= 4'd0;
      r_s1_hit  <= 1'b0;
      r_s2_de   <= 1'b0;
      r_s2_mode <= 2'd0;
      r_s2_col  <= 4'd0;
      r_s2_hit  <= 1'b0;
      r_s2_q    <= 16'd0;
    end else begin
      r_s1_de   <= de;
      r_s1_mode <= mode;
      r_s1_row  <= row[3:0];
      r_s1_col  <= col[3:0];
      r_s1_hit  <= w_cursor_hit;
      r_s2_de   <= r_s1_de;
      r_s2_mode <= r_s1_mode;
      r_s2_col  <= r_s1_col;
      r_s2_hit  <= r_s1_hit;
      r_s2_q    <= q;
    end
  end

  // The font address must leave in the same cycle q arrives so the ROM data
  // lines up with S2; otherwise the last driven address is held.
  logic        w_font_drive;
  logic [11:0] r_font_hold;

  assign w_font_drive = r_s1_de && (r_s1_mode == c_MODE_TEXT);
  assign font_address = w_font_drive ? {q[7:0], r_s1_row} : r_font_hold;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_font_hold <= 12'd0;
    end else begin
      r_font_hold <= font_address;
    end
  end

  // S2: pixel selection
  logic [7:0] w_attr;
  logic [3:0] w_fg;
  logic [3:0] w_bg;
  logic       w_glyph_bit;
  logic       w_text_on;
  logic [7:0] w_byte4;
  logic [1:0] w_val4;
  logic [7:0] w_pix;

  assign w_attr      = r_s2_q[15:8];
  assign w_fg        = w_attr[3:0];
  assign w_glyph_bit = font_data[~r_s2_col[2:0]];

`ifdef VGA_TEXT_BLINK_EN
  logic w_blink_phase;
  assign w_blink_phase = r_frame_count[4];
  assign w_bg          = {1'b0, w_attr[6:4]};
  assign w_text_on     = (w_glyph_bit & ~(w_attr[7] & w_blink_phase)) |
                         (r_s2_hit & ~w_blink_phase);
`else
  assign w_bg          = w_attr[7:4];
  assign w_text_on     = w_glyph_bit | r_s2_hit;
`endif

  assign w_byte4 = r_s2_col[3] ? r_s2_q[15:8] : r_s2_q[7:0];

  always_comb begin
    w_val4 = 2'd0;
    case (r_s2_col[2:1])
      2'd0:    w_val4 = w_byte4[7:6];
      2'd1:    w_val4 = w_byte4[5:4];
      2'd2:    w_val4 = w_byte4[3:2];
      default: w_val4 = w_byte4[1:0];
    endcase
  end

  always_comb begin
    w_pix = 8'd0;
    case (r_s2_mode)
      c_MODE_TEXT:      w_pix = {4'd0, w_text_on ? w_fg : w_bg};
      c_MODE_4_COLOR:   w_pix = {6'd0, w_val4};
      c_MODE_256_COLOR: w_pix = r_s2_col[1] ? r_s2_q[15:8] : r_s2_q[7:0];
      default:          w_pix = 8'd0;
    endcase
  end

  // S3: output registers
  logic [7:0] r_pixel;
  logic       r_pixel_valid;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel       <= 8'd0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_pixel       <= r_s2_de ? w_pix : 8'd0;
      r_pixel_valid <= r_s2_de;
    end
  end

  assign pixel       = r_pixel;
  assign pixel_valid = r_pixel_valid;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_render.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_vga_pixel_render
// Purpose  : Self-checking bench for vga_pixel_render with a behavioural model
//            and randomized scan bursts. Honours VGA_TEXT_BLINK_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vga_pixel_render;

  localparam logic [1:0] c_TEXT = 2'd0;
  localparam logic [1:0] c_C4   = 2'd1;
  localparam logic [1:0] c_C256 = 2'd2;
  localparam int         c_DEPTH = 8192;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        de = 1'b0;
  logic [9:0]  row = 10'd0;
  logic [9:0]  col = 10'd0;
  logic [15:0] q = 16'd0;
  logic [11:0] font_address;
  logic [7:0]  font_data = 8'd0;
  logic        cursor_enable = 1'b0;
  logic [4:0]  cursor_row = 5'd0;
  logic [6:0]  cursor_col = 7'd0;
  logic [7:0]  pixel;
  logic        pixel_valid;

  always #5 vga_clk = ~vga_clk;

  vga_pixel_render dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .mode          (mode),
    .de            (de),
    .row           (row),
    .col           (col),
    .q             (q),
    .font_address  (font_address),
    .font_data     (font_data),
    .cursor_enable (cursor_enable),
    .cursor_row    (cursor_row),
    .cursor_col    (cursor_col),
    .pixel         (pixel),
    .pixel_valid   (pixel_valid)
  );

  // Synchronous font ROM
  bit [7:0] rom [0:4095];
  always @(posedge vga_clk) font_data <= rom[font_address];

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  bit         exp_set [c_DEPTH];
  logic [7:0] exp_pix [c_DEPTH];
  bit         exp_val [c_DEPTH];
  bit         fa_set  [c_DEPTH];
  logic [11:0] fa_exp [c_DEPTH];
  bit         lit_set [c_DEPTH];
  logic [7:0] lit_pix [c_DEPTH];
  bit         lfa_set [c_DEPTH];
  logic [11:0] lfa_val [c_DEPTH];
  bit         rst_chk [c_DEPTH];

  int checks = 0;
  int passes = 0;

  // Model state
  logic [15:0] pend_word = 16'd0;
  bit          in_reset = 1'b1;
  bit          release_req = 1'b0;
  int          frames = 0;
  logic [11:0] last_fa = 12'd0;
  bit          fa_known = 1'b1;
  bit          cur_en_v = 1'b0;
  int          cur_row_v = 0;
  int          cur_col_v = 0;
  int          last_idx = 0;

  function automatic logic [7:0] model_pix(input logic [1:0] m, input int r, input int c,
                                           input logic [15:0] w, input bit hit);
    int  attr, glyph, b, p, byt, bg;
    bit  show;
    attr = int'(w[15:8]);
    case (m)
      c_TEXT: begin
        glyph = int'(rom[int'(w[7:0]) * 16 + r % 16]);
        b = (glyph >> (7 - c % 8)) & 1;
`ifdef VGA_TEXT_BLINK_EN
        if (attr >= 128 && frames >= 16) b = 0;
        show = hit && (frames < 16);
        bg = (attr / 16) % 8;
`else
        show = hit;
        bg = attr / 16;
`endif
        return 8'((b == 1 || show) ? attr % 16 : bg);
      end
      c_C4: begin
        p = (c % 16) / 2;
        byt = (p < 4) ? int'(w[7:0]) : attr;
        return 8'((byt >> (6 - 2 * (p % 4))) & 3);
      end
      c_C256: return ((c % 4) < 2) ? w[7:0] : w[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic step(input bit d, input int r, input int c, input logic [1:0] m,
                      input logic [15:0] w);
    int idx;
    bit hit;
    @(posedge vga_clk);
    #1;
    idx = cyc;
    last_idx = idx;
    q = pend_word;
    pend_word = w;
    de = d;
    row = r[9:0];
    col = c[9:0];
    mode = m;
    cursor_enable = cur_en_v;
    cursor_row = cur_row_v[4:0];
    cursor_col = cur_col_v[6:0];
    if (release_req) begin
      reset_n = 1'b1;
      release_req = 1'b0;
      in_reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_set[idx + k] = 1'b1;
        exp_pix[idx + k] = 8'h00;
        exp_val[idx + k] = 1'b0;
      end
    end else if (in_reset) begin
      rst_chk[idx] = 1'b1;
    end
    if (!in_reset && idx + 3 < c_DEPTH) begin
      if (d && r == 0 && c == 0) frames = (frames + 1) % 32;
      hit = cur_en_v && (r / 16 == cur_row_v) && (c / 8 == cur_col_v) &&
            (r % 16 >= 14) && (r % 16 <= 15);
      exp_set[idx + 3] = 1'b1;
      exp_val[idx + 3] = d;
      exp_pix[idx + 3] = d ? model_pix(m, r, c, w, hit) : 8'h00;
      if (d && m == c_TEXT) begin
        last_fa = {w[7:0], 4'(r % 16)};
        fa_known = 1'b1;
        fa_set[idx + 1] = 1'b1;
        fa_exp[idx + 1] = last_fa;
      end else if (m == c_TEXT) begin
        fa_known = 1'b0;
      end else if (fa_known) begin
        fa_set[idx + 1] = 1'b1;
        fa_exp[idx + 1] = last_fa;
      end
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, c_TEXT, 16'($urandom));
  endtask

  task automatic advance_frame();
    blank(2);
    step(1'b1, 0, 0, c_TEXT, 16'($urandom));
    blank(2);
  endtask

  task automatic lit(input logic [7:0] v);
    lit_set[last_idx + 3] = 1'b1;
    lit_pix[last_idx + 3] = v;
  endtask

  task automatic assert_reset();
    #2;
    reset_n = 1'b0;
    in_reset = 1'b1;
    rst_chk[last_idx] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_set[last_idx + k] = 1'b0;
      fa_set[last_idx + k]  = 1'b0;
      lit_set[last_idx + k] = 1'b0;
      lfa_set[last_idx + k] = 1'b0;
    end
    frames = 0;
    last_fa = 12'd0;
    fa_known = 1'b1;
  endtask

  // Compare process
  initial begin
    forever begin
      @(negedge vga_clk);
      if (cyc < c_DEPTH) begin
        if (!reset_n && rst_chk[cyc]) begin
          checks++;
          if (pixel === 8'h00 && pixel_valid === 1'b0 && font_address === 12'h000) passes++;
          else $display("FAIL reset cyc=%0d pixel=%h valid=%b fa=%h required 00/0/000",
                        cyc, pixel, pixel_valid, font_address);
        end
        if (reset_n && exp_set[cyc]) begin
          checks++;
          if (pixel === exp_pix[cyc] && pixel_valid === exp_val[cyc]) passes++;
          else $display("FAIL pixel cyc=%0d got %h/%b required %h/%b",
                        cyc, pixel, pixel_valid, exp_pix[cyc], exp_val[cyc]);
        end
        if (reset_n && fa_set[cyc]) begin
          checks++;
          if (font_address === fa_exp[cyc]) passes++;
          else $display("FAIL font_address cyc=%0d got %h required %h",
                        cyc, font_address, fa_exp[cyc]);
        end
        if (reset_n && lit_set[cyc]) begin
          checks++;
          if (pixel === lit_pix[cyc]) passes++;
          else $display("FAIL literal_pixel cyc=%0d got %h required %h",
                        cyc, pixel, lit_pix[cyc]);
        end
        if (reset_n && lfa_set[cyc]) begin
          checks++;
          if (font_address === lfa_val[cyc]) passes++;
          else $display("FAIL literal_font_address cyc=%0d got %h required %h",
                        cyc, font_address, lfa_val[cyc]);
        end
      end
    end
  end

  initial begin
    int         r0, c0, len;
    bit         d;
    logic [1:0] m;
    logic [7:0] seq4 [8];
    logic [7:0] blink_exp;

    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h415] = 8'h81;
    rom[12'h20D] = 8'h00;
    rom[12'h20E] = 8'h00;
    rom[12'h20F] = 8'h00;
    rom[12'h335] = 8'hFF;

    blank(3);
    release_req = 1'b1;
    blank(4);

    // 256-colour: one word covers four columns
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 10, c, c_C256, 16'hA55A);
      lit((c < 2) ? 8'h5A : 8'hA5);
    end
    blank(1);

    // 4-colour: doubled 2-bit pixels, low byte first
    seq4 = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 20, c, c_C4, 16'h1BE4);
      lit(seq4[c / 2]);
    end
    blank(1);

    // Text glyph lookup
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 5, c, c_TEXT, 16'h1F41);
      lit((c == 0 || c == 7) ? 8'h0F : 8'h01);
      lfa_set[last_idx + 1] = 1'b1;
      lfa_val[last_idx + 1] = 12'h415;
    end
    blank(1);

    // Underline cursor at char (2,10), frame phase 0
    cur_en_v = 1'b1; cur_row_v = 2; cur_col_v = 10;
    for (int r = 45; r <= 47; r++) begin
      for (int c = 78; c < 90; c++) begin
        step(1'b1, r, c, c_TEXT, 16'h1E20);
        lit((r != 45 && c >= 80 && c <= 87) ? 8'h0E : 8'h01);
      end
    end
    blank(1);

    repeat (16) advance_frame();

    // Frames 16..31: cursor and blink attribute
    for (int c = 78; c < 90; c++) begin
      step(1'b1, 46, c, c_TEXT, 16'h1E20);
`ifdef VGA_TEXT_BLINK_EN
      lit(8'h01);
`else
      lit((c >= 80 && c <= 87) ? 8'h0E : 8'h01);
`endif
    end
`ifdef VGA_TEXT_BLINK_EN
    blink_exp = 8'h04;
`else
    blink_exp = 8'h07;
`endif
    for (int c = 8; c < 16; c++) begin
      step(1'b1, 5, c, c_TEXT, 16'hC733);
      lit(blink_exp);
    end
    blank(1);

    // Wrap 31 -> 0 restores phase 0
    repeat (16) advance_frame();
    for (int c = 8; c < 16; c++) begin
      step(1'b1, 5, c, c_TEXT, 16'hC733);
      lit(8'h07);
    end
    blank(1);

    // Randomized scan bursts
    for (int b = 0; b < 90; b++) begin
      r0 = $urandom_range(399, 1);
      if ($urandom_range(1, 0) == 1) r0 = (r0 & ~15) | $urandom_range(15, 12);
      if (r0 > 399) r0 = 399;
      c0 = $urandom_range(620, 0);
      len = $urandom_range(20, 4);
      m = 2'($urandom_range(3, 0));
      cur_en_v = ($urandom_range(3, 0) != 0);
      cur_row_v = r0 / 16;
      cur_col_v = c0 / 8 + $urandom_range(2, 0);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(7, 0) == 0) m = 2'($urandom_range(3, 0));
        d = ($urandom_range(9, 0) != 0);
        step(d, r0, c0 + k, m, 16'($urandom));
      end
      if (b % 9 == 8) repeat ($urandom_range(12, 1)) advance_frame();
    end
    cur_en_v = 1'b0;
    blank(2);

    // Asynchronous reset in the middle of an active line
    for (int c = 40; c < 48; c++) step(1'b1, 100, c, c_C256, 16'($urandom));
    assert_reset();
    for (int c = 48; c < 50; c++) step(1'b1, 100, c, c_C256, 16'($urandom));
    release_req = 1'b1;
    for (int c = 50; c < 60; c++) step(1'b1, 100, c, c_C256, 16'($urandom));
    blank(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
